led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pkg.sv | 37 +++
 rtl/key_debounce.sv | 49 ++++
 rtl/led_pattern_ctrl.sv | 136 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: mode encoding,
// per-mode entry patterns and the number of speed settings.
package led_pkg;

    typedef enum logic [1:0] {
        FLOW_L   = 2'd0,
        FLOW_R   = 2'd1,
        PINGPONG = 2'd2,
        BLINK    = 2'd3
    } mode_e;

    localparam logic [3:0] ENTRY_FLOW_L   = 4'b0001;
    localparam logic [3:0] ENTRY_FLOW_R   = 4'b1000;
    localparam logic [3:0] ENTRY_PINGPONG = 4'b0001;
    localparam logic [3:0] ENTRY_BLINK    = 4'b0000;

    localparam logic [1:0] SPEED_COUNT = 2'd3;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            FLOW_L:   return FLOW_R;
            FLOW_R:   return PINGPONG;
            PINGPONG: return BLINK;
            default:  return FLOW_L;
        endcase
    endfunction

    function automatic logic [3:0] entry_led(input mode_e m);
        case (m)
            FLOW_L:   return ENTRY_FLOW_L;
            FLOW_R:   return ENTRY_FLOW_R;
            PINGPONG: return ENTRY_PINGPONG;
            default:  return ENTRY_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, ms-tick based stability
// filter and a single-cycle pulse on each accepted press (high-to-low).
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic key,
    output logic press
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [DW-1:0] stable_cnt;
    logic          mismatch;
    logic          accept;

    // The press pulse is aligned with the accepting ms_tick so it can collide with a step event.
    assign mismatch = (sync_2 != level);
    assign accept   = mismatch && ms_tick && (stable_cnt == DW'(DEBOUNCE_MS - 1));
    assign press    = accept && level;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            level      <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
            if (!mismatch) begin
                stable_cnt <= '0;
            end else if (ms_tick) begin
                if (accept) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern generator with mode/speed push-buttons, a 1 ms
// prescaler and a speed-scaled step timer.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int STEP_MS     = 200,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       step_pulse
);

    localparam int MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int MW     = $clog2(MS_DIV + 1);
    localparam int SW     = $clog2(STEP_MS + 1);

    logic [MW-1:0] ms_cnt;
    logic          ms_tick;
    logic          mode_press;
    logic          speed_press;

    mode_e         mode_q,     mode_d;
    logic [3:0]    led_q,      led_d;
    logic [1:0]    speed_q,    speed_d;
    logic          dir_q,      dir_d;
    logic [SW-1:0] step_cnt,   step_cnt_d;
    logic          pulse_q,    pulse_d;
    logic [SW-1:0] period_m1;
    logic          step_event;

    assign ms_tick = (ms_cnt == MW'(MS_DIV - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
        end
    end

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_key (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .ms_tick (ms_tick),
        .key     (key_mode),
        .press   (mode_press)
    );

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_speed_key (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .ms_tick (ms_tick),
        .key     (key_speed),
        .press   (speed_press)
    );

    always_comb begin
        case (speed_q)
            2'd0:    period_m1 = SW'(STEP_MS - 1);
            2'd1:    period_m1 = SW'(STEP_MS / 2 - 1);
            default: period_m1 = SW'(STEP_MS / 4 - 1);
        endcase
    end

    assign step_event = ms_tick && (step_cnt == period_m1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= FLOW_L;
            led_q    <= ENTRY_FLOW_L;
            speed_q  <= 2'd0;
            dir_q    <= 1'b0;
            step_cnt <= '0;
            pulse_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            speed_q  <= speed_d;
            dir_q    <= dir_d;
            step_cnt <= step_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Later assignments win: a mode press overrides any step in the same cycle.
    always_comb begin
        mode_d     = mode_q;
        led_d      = led_q;
        speed_d    = speed_q;
        dir_d      = dir_q;
        step_cnt_d = ms_tick ? step_cnt + 1'b1 : step_cnt;
        pulse_d    = 1'b0;

        if (step_event) begin
            step_cnt_d = '0;
            pulse_d    = 1'b1;
            case (mode_q)
                FLOW_L: led_d = {led_q[2:0], led_q[3]};
                FLOW_R: led_d = {led_q[0], led_q[3:1]};
                PINGPONG: begin
                    led_d = dir_q ? (led_q >> 1) : (led_q << 1);
                    if (led_d == 4'b1000 || led_d == 4'b0001) begin
                        dir_d = ~dir_q;
                    end
                end
                default: led_d = ~led_q;
            endcase
        end

        if (speed_press) begin
            speed_d    = (speed_q == SPEED_COUNT - 2'd1) ? 2'd0 : speed_q + 2'd1;
            step_cnt_d = '0;
        end

        if (mode_press) begin
            mode_d     = next_mode(mode_q);
            led_d      = entry_led(mode_d);
            dir_d      = 1'b0;
            step_cnt_d = '0;
            pulse_d    = 1'b0;
        end
    end

    assign led        = led_q;
    assign mode       = mode_q;
    assign speed      = speed_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at 4 kHz / 4 ms steps / 2 ms debounce,
// so one ms_tick every 4 clocks and one base step every 16 clocks.
module tb_led_pattern_ctrl;

    logic       sys_clk   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_mode  = 1'b1;
    logic       key_speed = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       step_pulse;

    int total = 0;
    int bad   = 0;

    int         gap;
    logic       seen;
    int         since;
    logic       pulse_at, pulse_after;
    logic [3:0] led_at, led_after;
    logic [3:0] pp_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                               4'b0010, 4'b0001, 4'b0010, 4'b0100};

    led_pattern_ctrl #(
        .CLK_FREQ_HZ (4000),
        .STEP_MS     (4),
        .DEBOUNCE_MS (2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .key_mode   (key_mode),
        .key_speed  (key_speed),
        .led        (led),
        .mode       (mode),
        .speed      (speed),
        .step_pulse (step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Counts clocks until the next step_pulse, giving up after 64.
    task automatic waitStep(output int n);
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!step_pulse && n < 64);
        checkOutput("step_seen", {7'd0, step_pulse}, 8'd1);
    endtask

    task automatic applyStimulus(input bit use_speed, input int low_cycles);
        if (use_speed) key_speed = 1'b0;
        else           key_mode  = 1'b0;
        cycles(low_cycles);
        key_mode  = 1'b1;
        key_speed = 1'b1;
    endtask

    initial begin
        cycles(3);
        checkOutput("rst_led",   {4'd0, led},        8'h01);
        checkOutput("rst_mode",  {6'd0, mode},       8'h00);
        checkOutput("rst_speed", {6'd0, speed},      8'h00);
        checkOutput("rst_pulse", {7'd0, step_pulse}, 8'h00);

        // Free-running FLOW_L after reset release
        rst_n = 1'b1;
        waitStep(gap);
        checkOutput("first_gap", 8'(gap), 8'd16);
        checkOutput("fl_0", {4'd0, led}, 8'b0010);
        waitStep(gap);
        checkOutput("fl_gap", 8'(gap), 8'd16);
        checkOutput("fl_1", {4'd0, led}, 8'b0100);
        waitStep(gap);
        checkOutput("fl_2", {4'd0, led}, 8'b1000);
        waitStep(gap);
        checkOutput("fl_3", {4'd0, led}, 8'b0001);

        // 3 ms mode press -> FLOW_R
        applyStimulus(1'b0, 12);
        checkOutput("press_mode", {6'd0, mode}, 8'd1);
        checkOutput("press_led",  {4'd0, led},  8'b1000);
        waitStep(gap);
        checkOutput("fr_0", {4'd0, led}, 8'b0100);
        waitStep(gap);
        checkOutput("fr_1", {4'd0, led}, 8'b0010);

        // 1 ms glitch is rejected
        applyStimulus(1'b0, 4);
        cycles(8);
        checkOutput("glitch_mode", {6'd0, mode}, 8'd1);
        checkOutput("glitch_led",  {4'd0, led},  8'b0010);

        // PINGPONG sequence
        waitStep(gap);
        checkOutput("fr_2", {4'd0, led}, 8'b0001);
        applyStimulus(1'b0, 12);
        checkOutput("pp_mode",  {6'd0, mode}, 8'd2);
        checkOutput("pp_entry", {4'd0, led},  8'b0001);
        for (int i = 0; i < 8; i++) begin
            waitStep(gap);
            checkOutput($sformatf("pp_%0d", i), {4'd0, led}, {4'd0, pp_seq[i]});
        end

        // Speed presses
        applyStimulus(1'b1, 12);
        checkOutput("speed_1",    {6'd0, speed}, 8'd1);
        checkOutput("speed_mode", {6'd0, mode},  8'd2);
        cycles(16);
        waitStep(gap);
        waitStep(gap);
        checkOutput("gap_speed1", 8'(gap), 8'd8);
        applyStimulus(1'b1, 12);
        checkOutput("speed_2", {6'd0, speed}, 8'd2);
        cycles(16);
        waitStep(gap);
        waitStep(gap);
        checkOutput("gap_speed2", 8'(gap), 8'd4);

        // At speed 2 every ms_tick is a step, so the mode press collides with one
        seen = 1'b0; since = 0;
        pulse_at = 1'b1; led_at = 4'hF; pulse_after = 1'b0; led_after = 4'h0;
        key_mode = 1'b0;
        for (int i = 0; i < 28; i++) begin
            cycles(1);
            if (i == 11) key_mode = 1'b1;
            if (!seen && mode == 2'd3) begin
                seen     = 1'b1;
                pulse_at = step_pulse;
                led_at   = led;
            end else if (seen) begin
                since++;
                if (since == 4) begin
                    pulse_after = step_pulse;
                    led_after   = led;
                end
            end
        end
        checkOutput("blink_seen",  {7'd0, seen},        8'd1);
        checkOutput("blink_mode",  {6'd0, mode},        8'd3);
        checkOutput("clash_pulse", {7'd0, pulse_at},    8'd0);
        checkOutput("clash_led",   {4'd0, led_at},      8'b0000);
        checkOutput("blink_pulse", {7'd0, pulse_after}, 8'd1);
        checkOutput("blink_led",   {4'd0, led_after},   8'b1111);

        applyStimulus(1'b1, 12);
        checkOutput("speed_wrap", {6'd0, speed}, 8'd0);
        checkOutput("wrap_mode",  {6'd0, mode},  8'd3);

        // Reset mid-step and mid-debounce
        cycles(16);
        waitStep(gap);
        cycles(6);
        key_mode = 1'b0;
        cycles(5);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_led",   {4'd0, led},        8'h01);
        checkOutput("mid_rst_mode",  {6'd0, mode},       8'h00);
        checkOutput("mid_rst_speed", {6'd0, speed},      8'h00);
        checkOutput("mid_rst_pulse", {7'd0, step_pulse}, 8'h00);
        cycles(2);
        key_mode = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        waitStep(gap);
        checkOutput("post_rst_gap",  8'(gap),       8'd16);
        checkOutput("post_rst_led",  {4'd0, led},   8'b0010);
        checkOutput("post_rst_mode", {6'd0, mode},  8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
